// File: rtl/mips_exec_core_if.sv
// Instruction/result handshake bundle between the fetch stage, the execution core and writeback.
// No logic: carries the instr valid/ready channel and the result valid/ready channel.
// The master side offers instructions and accepts results; the slave side (the core) does the reverse.
interface mips_exec_core_if #(
    parameter int XLEN = 32
);
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            res_zero;
    logic [4:0]      res_wreg;
    logic            res_wen;
    logic            res_illegal;
    logic            busy;

    modport master (
        output instr_valid, instr, res_ready,
        input  instr_ready, res_valid, res_data, res_zero, res_wreg, res_wen, res_illegal, busy
    );

    modport slave (
        input  instr_valid, instr, res_ready,
        output instr_ready, res_valid, res_data, res_zero, res_wreg, res_wen, res_illegal, busy
    );
endinterface

// File: rtl/mips_exec_core.sv
// Multi-cycle MIPS execution core: private regfile, ALU, optional shift-add multiplier (MIPS_MULT_EN).
// Latency: result valid 3 cycles after accept (XLEN+2 for MULT/MULTU); one instruction per 4 cycles max.
// Backpressure: result held stable in RESP until res_ready; no new instruction accepted meanwhile.
module mips_exec_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_exec_core_if.slave   bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] a_q, b_q, res_q, res_d;
    logic [XLEN-1:0] rf_q [NREGS];

    // Instruction fields of the latched instruction
    logic [5:0]      opcode, funct;
    logic [4:0]      shamt, dst_field;
    logic [15:0]     imm16;
    logic [AW-1:0]   rs_idx, rt_idx, dst_idx;
    logic [XLEN-1:0] rs_val, rt_val, imm_ext, res_val_c;
    logic            is_r_c, legal_c, mul_c, wen_c;
    logic [4:0]      wreg_c;

    assign opcode    = instr_q[31:26];
    assign funct     = instr_q[5:0];
    assign shamt     = instr_q[10:6];
    assign imm16     = instr_q[15:0];
    assign rs_idx    = instr_q[21 +: AW];
    assign rt_idx    = instr_q[16 +: AW];
    assign is_r_c    = (opcode == 6'h00);
    assign dst_field = is_r_c ? instr_q[15:11] : instr_q[20:16];
    assign rs_val    = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val    = (rt_idx == '0) ? '0 : rf_q[rt_idx];

`ifdef MIPS_MULT_EN
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic [XLEN-1:0]   hi_q, lo_q, mplier_q, mag_a_c, mag_b_c;
    logic [2*XLEN-1:0] acc_q, mcand_q, prod_c;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, mul_signed_c;

    // Signed multiply runs on magnitudes; the sign is reapplied to the full double-width product
    assign mul_signed_c = (funct == 6'h18);
    assign mag_a_c      = (mul_signed_c && rs_val[XLEN-1]) ? -rs_val : rs_val;
    assign mag_b_c      = (mul_signed_c && rt_val[XLEN-1]) ? -rt_val : rt_val;
    assign prod_c       = neg_q ? -acc_q : acc_q;
`endif

    // Legality and class of the latched instruction
    always_comb begin
        legal_c = 1'b0;
        mul_c   = 1'b0;
        if (is_r_c) begin
            case (funct)
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: legal_c = 1'b1;
`ifdef MIPS_MULT_EN
                6'h18, 6'h19: begin
                    legal_c = 1'b1;
                    mul_c   = 1'b1;
                end
                6'h10, 6'h12: legal_c = 1'b1;
`endif
                default: legal_c = 1'b0;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: legal_c = 1'b1;
                default: legal_c = 1'b0;
            endcase
        end
    end

    // Destination: multiplies and illegal instructions name no register
    assign wreg_c  = (legal_c && !mul_c) ? dst_field : 5'd0;
    assign dst_idx = wreg_c[AW-1:0];
    assign wen_c   = legal_c && !mul_c && (dst_idx != '0);

    // Immediate extension: logical ops zero-extend, LUI shifts the sign-extended value up
    always_comb begin
        imm_ext = {{(XLEN-16){imm16[15]}}, imm16};
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_ext = {{(XLEN-16){1'b0}}, imm16};
            6'h0F:               imm_ext = {{(XLEN-16){imm16[15]}}, imm16} << 16;
            default:             imm_ext = {{(XLEN-16){imm16[15]}}, imm16};
        endcase
    end

    // ALU result for single-cycle operations
    always_comb begin
        res_d = '0;
        if (is_r_c) begin
            case (funct)
                6'h20, 6'h21: res_d = a_q + b_q;
                6'h22, 6'h23: res_d = a_q - b_q;
                6'h24:        res_d = a_q & b_q;
                6'h25:        res_d = a_q | b_q;
                6'h26:        res_d = a_q ^ b_q;
                6'h27:        res_d = ~(a_q | b_q);
                6'h2A:        res_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                6'h2B:        res_d = {{(XLEN-1){1'b0}}, a_q < b_q};
                6'h00:        res_d = b_q << shamt;
                6'h02:        res_d = b_q >> shamt;
                6'h03:        res_d = $unsigned($signed(b_q) >>> shamt);
`ifdef MIPS_MULT_EN
                6'h10:        res_d = hi_q;
                6'h12:        res_d = lo_q;
`endif
                default:      res_d = '0;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09: res_d = a_q + b_q;
                6'h0A:        res_d = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                6'h0B:        res_d = {{(XLEN-1){1'b0}}, a_q < b_q};
                6'h0C:        res_d = a_q & b_q;
                6'h0D:        res_d = a_q | b_q;
                6'h0E:        res_d = a_q ^ b_q;
                6'h0F:        res_d = b_q;
                default:      res_d = '0;
            endcase
        end
    end

    // Value presented in RESP and written back on the handshake
    always_comb begin
        res_val_c = res_q;
`ifdef MIPS_MULT_EN
        if (mul_c) res_val_c = prod_c[XLEN-1:0];
`endif
        if (!legal_c) res_val_c = '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and handshake outputs; result outputs are zero outside RESP
    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_data    = '0;
        bus.res_zero    = 1'b0;
        bus.res_wreg    = 5'd0;
        bus.res_wen     = 1'b0;
        bus.res_illegal = 1'b0;
        bus.busy        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_RESP;
`ifdef MIPS_MULT_EN
                if (mul_c && (cnt_q != CNT_LAST)) state_d = S_EXEC;
`endif
            end
            S_RESP: begin
                bus.res_valid   = 1'b1;
                bus.res_data    = res_val_c;
                bus.res_zero    = (res_val_c == '0);
                bus.res_wreg    = wreg_c;
                bus.res_wen     = wen_c;
                bus.res_illegal = !legal_c;
                if (bus.res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch instruction, operands, result, multiplier state and register writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
`ifdef MIPS_MULT_EN
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (bus.instr_valid) instr_q <= bus.instr;
                S_DECODE: begin
                    a_q <= rs_val;
                    b_q <= is_r_c ? rt_val : imm_ext;
`ifdef MIPS_MULT_EN
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    mcand_q  <= {{XLEN{1'b0}}, mag_a_c};
                    mplier_q <= mag_b_c;
                    neg_q    <= mul_signed_c && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
`endif
                end
                S_EXEC: begin
                    res_q <= res_d;
`ifdef MIPS_MULT_EN
                    if (mul_c) begin
                        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        if (wen_c) rf_q[dst_idx] <= res_val_c;
`ifdef MIPS_MULT_EN
                        if (mul_c) {hi_q, lo_q} <= prod_c;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_exec_core.sv
module tb_mips_exec_core;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_exec_core_if #(.XLEN(XLEN)) bus ();
    mips_exec_core #(.XLEN(XLEN), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] mrf [32];
    logic [31:0] mhi, mlo;
    logic [31:0] last_data;
    time         t0, t1, t2;

    logic [5:0] rfn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h18, 6'h19, 6'h10, 6'h12};
    logic [5:0] iop [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
        logic [4:0] a, b, c, s;
        a = rs[4:0]; b = rt[4:0]; c = rd[4:0]; s = sh[4:0];
        return {6'h00, a, b, c, s, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] a, b;
        a = rs[4:0]; b = rt[4:0];
        return {op, a, b, imm};
    endfunction

    // Architectural reference: what the instruction means, from current model state
    task automatic model(input logic [31:0] ins, output logic [31:0] d, output logic [4:0] wr,
                         output logic we, output logic ill, output logic mul,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        logic [5:0] op, fn;
        logic [31:0] a, b, si, zi;
        logic [4:0] sh;
        logic signed [63:0] p;
        op = ins[31:26]; fn = ins[5:0]; sh = ins[10:6];
        a = mrf[ins[25:21]]; b = mrf[ins[20:16]];
        si = {{16{ins[15]}}, ins[15:0]}; zi = {16'h0, ins[15:0]};
        d = 32'd0; ill = 1'b0; mul = 1'b0; nhi = mhi; nlo = mlo; p = '0;
        wr = (op == 6'h00) ? ins[15:11] : ins[20:16];
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: d = a + b;
                6'h22, 6'h23: d = a - b;
                6'h24: d = a & b;
                6'h25: d = a | b;
                6'h26: d = a ^ b;
                6'h27: d = ~(a | b);
                6'h2A: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: d = (a < b) ? 32'd1 : 32'd0;
                6'h00: d = b << sh;
                6'h02: d = b >> sh;
                6'h03: d = $unsigned($signed(b) >>> sh);
`ifdef MIPS_MULT_EN
                6'h18: begin
                    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                    mul = 1'b1; {nhi, nlo} = p; d = p[31:0];
                end
                6'h19: begin
                    p = {32'h0, a} * {32'h0, b};
                    mul = 1'b1; {nhi, nlo} = p; d = p[31:0];
                end
                6'h10: d = mhi;
                6'h12: d = mlo;
`endif
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: d = a + si;
                6'h0A: d = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
                6'h0B: d = (a < si) ? 32'd1 : 32'd0;
                6'h0C: d = a & zi;
                6'h0D: d = a | zi;
                6'h0E: d = a ^ zi;
                6'h0F: d = {ins[15:0], 16'h0};
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin d = 32'd0; wr = 5'd0; end
        if (mul) wr = 5'd0;
        we = !ill && !mul && (wr != 5'd0);
    endtask

    // Issue one instruction from IDLE (called at a negedge), hold the result `stall` cycles, retire it
    task automatic run(input logic [31:0] ins, input int stall, output time acc);
        logic [31:0] d, nhi, nlo;
        logic [4:0] wr;
        logic we, ill, mul;
        int lat, exp_lat;
        model(ins, d, wr, we, ill, mul, nhi, nlo);
        exp_lat = mul ? XLEN + 2 : 3;
        check("idle_rdy", bus.instr_ready, 1);
        bus.instr = ins; bus.instr_valid = 1'b1; bus.res_ready = (stall == 0);
        @(posedge clk);
        acc = $time;
        #1 bus.instr_valid = 1'b0; bus.instr = $urandom;
        @(negedge clk);
        lat = 1;
        while (!bus.res_valid && lat < 100) begin
            check("busy_exec", bus.busy, 1);
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("res_data", bus.res_data, d);
        check("res_zero", bus.res_zero, (d == 32'd0));
        check("res_wreg", bus.res_wreg, wr);
        check("res_wen", bus.res_wen, we);
        check("res_illegal", bus.res_illegal, ill);
        check("rdy_in_resp", bus.instr_ready, 0);
        last_data = bus.res_data;
        for (int s = 0; s < stall; s++) begin
            bus.instr_valid = 1'b1; bus.instr = $urandom;
            @(negedge clk);
            check("stall_valid", bus.res_valid, 1);
            check("stall_data", bus.res_data, d);
            check("stall_wen", bus.res_wen, we);
            check("stall_rdy", bus.instr_ready, 0);
        end
        bus.instr_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        if (we) mrf[wr] = d;
        if (mul) begin mhi = nhi; mlo = nlo; end
        @(negedge clk);
        check("post_valid", bus.res_valid, 0);
        check("post_rdy", bus.instr_ready, 1);
    endtask

    initial begin
        bus.instr_valid = 1'b0; bus.instr = '0; bus.res_ready = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        mhi = '0; mlo = '0; last_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #12;
        check("rst_rdy", bus.instr_ready, 1);
        check("rst_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_data", bus.res_data, 0);
        check("rst_zero", bus.res_zero, 0);
        check("rst_wen", bus.res_wen, 0);
        check("rst_ill", bus.res_illegal, 0);
        check("rst_wreg", bus.res_wreg, 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed arithmetic and set-less-than
        run(32'h2001FFFB, 0, t0);                       check("addi_m5", last_data, 32'hFFFFFFFB);
        run(enc_r(0, 1, 2, 0, 6'h2B), 0, t0);           check("sltu", last_data, 32'd1);
        run(enc_r(1, 0, 3, 0, 6'h2A), 0, t0);           check("slt", last_data, 32'd1);
        // Shifts
        run(enc_i(6'h0F, 0, 4, 16'h8000), 0, t0);       check("lui", last_data, 32'h80000000);
        run(enc_r(0, 4, 5, 4, 6'h03), 0, t0);           check("sra", last_data, 32'hF8000000);
        run(enc_r(0, 4, 9, 4, 6'h02), 0, t0);           check("srl", last_data, 32'h08000000);
        run(enc_r(5, 5, 6, 0, 6'h22), 0, t0);           check("sub_zero", last_data, 32'd0);
        // Backpressure, then back-to-back throughput
        run(enc_i(6'h08, 0, 10, 16'h0055), 5, t0);
        run(enc_r(10, 0, 11, 0, 6'h21), 0, t0);         check("after_stall", last_data, 32'h55);
        run(enc_i(6'h08, 11, 12, 16'h0001), 0, t1);
        run(enc_i(6'h08, 12, 12, 16'h0001), 0, t2);
        check("thru_1", t1 - t0, 40);
        check("thru_2", t2 - t1, 40);
        // r0 stays zero; illegal opcode
        run(enc_i(6'h08, 0, 0, 16'h0007), 0, t0);
        run(enc_r(0, 0, 13, 0, 6'h20), 0, t0);          check("r0_read", last_data, 32'd0);
        run(enc_i(6'h3F, 1, 14, 16'h1234), 0, t0);
        run(enc_r(14, 0, 15, 0, 6'h20), 0, t0);         check("ill_nowrite", last_data, 32'd0);

        // Reset while ADDI r7 is in EXEC: discarded, r7 never written
        bus.instr = enc_i(6'h08, 0, 7, 16'h0009); bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", bus.instr_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.res_valid, 0);
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        mhi = '0; mlo = '0;
        @(negedge clk) rst_n = 1'b1;
        run(enc_r(7, 0, 8, 0, 6'h20), 0, t0);           check("r7_zero", last_data, 32'd0);
        run(enc_r(4, 0, 8, 0, 6'h20), 0, t0);           check("r4_cleared", last_data, 32'd0);

`ifdef MIPS_MULT_EN
        run(enc_i(6'h08, 0, 1, 16'hFFFD), 0, t0);
        run(enc_i(6'h08, 0, 2, 16'h0007), 0, t0);
        run(enc_r(1, 2, 0, 0, 6'h18), 0, t0);
        run(enc_r(0, 0, 3, 0, 6'h12), 0, t0);           check("mflo", last_data, 32'hFFFFFFEB);
        run(enc_r(0, 0, 3, 0, 6'h10), 0, t0);           check("mfhi", last_data, 32'hFFFFFFFF);
        run(enc_i(6'h08, 0, 1, 16'hFFFF), 0, t0);
        run(enc_i(6'h08, 0, 2, 16'h0002), 0, t0);
        run(enc_r(1, 2, 0, 0, 6'h19), 0, t0);
        run(enc_r(0, 0, 3, 0, 6'h10), 0, t0);           check("multu_hi", last_data, 32'h1);
        run(enc_r(0, 0, 3, 0, 6'h12), 0, t0);           check("multu_lo", last_data, 32'hFFFFFFFE);
`endif

        // Seed r1..r7 with random values, then random mix against the reference model
        for (int r = 1; r < 8; r++) begin
            run(enc_i(6'h0F, 0, r, 16'($urandom)), 0, t0);
            run(enc_i(6'h0D, r, r, 16'($urandom)), 0, t0);
        end
        for (int k = 0; k < 60; k++) begin
            int sel;
            logic [31:0] ins;
            sel = $urandom_range(0, 25);
            if (sel < 17)
                ins = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 31), rfn[sel]);
            else if (sel < 25)
                ins = enc_i(iop[sel-17], $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
            else
                ins = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 0, 6'h3F);
            run(ins, $urandom_range(0, 3), t0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_exec_core.md
# mips_exec_core

Multi-cycle, parametrised execution core for the MIPS processor: accepts one 32-bit instruction at a time over a valid/ready handshake, reads its private register file, performs the ALU (and optionally multiply) operation over a small state machine, and returns the result over a second valid/ready handshake with the register-file write committed on acceptance. It supersedes the combinational single-cycle control/regfile/ALU path as the unit the fetch stage feeds and the trace/writeback logic consumes.

## Interface
- XLEN, 32, datapath width; legal 32 or 64
- NREGS, 32, register count; power of two, 2..32; register specifiers use the low $clog2(NREGS) bits of each 5-bit field
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  core can accept (high only in IDLE)
- instr  in  32  MIPS instruction word
- res_valid  out  1  result presented
- res_ready  in  1  consumer accepts result
- res_data  out  XLEN  result value
- res_zero  out  1  res_data == 0
- res_wreg  out  5  destination register (rd R-type, rt I-type)
- res_wen  out  1  result writes res_wreg
- res_illegal  out  1  unsupported opcode/funct
- busy  out  1  state != IDLE

## Operation
- States: IDLE -> DECODE -> EXEC -> RESP -> IDLE.
- IDLE: instr_ready=1; on instr_valid&&instr_ready latch instr, go DECODE.
- DECODE: read rs/rt, sign-extend imm16 to XLEN (zero-extend for ANDI/ORI/XORI), latch operands; go EXEC.
- EXEC: compute result, go RESP (multiply stays here, see Configuration).
- RESP: res_valid=1, outputs stable; on res_ready: if res_wen write regfile, go IDLE.
- R-type (opcode 0x00) funct: ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B, SLL 0x00, SRL 0x02, SRA 0x03 (shift by shamt[10:6]).
- I-type opcodes: ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F (imm16<<16, sign-extended to XLEN).
- Arithmetic wraps modulo 2^XLEN; ADD/ADDI never trap (same as unsigned forms). SLT/SLTI signed, SLTU/SLTIU unsigned (SLTIU compares against sign-extended imm). Set results are 0 or 1.
- Register 0 reads 0; res_wen=0 when destination index (after truncation to NREGS) is 0.
- Illegal instruction: res_illegal=1, res_wen=0, res_data=0, res_zero=1; still completes a normal RESP handshake.
- Reset (any state): state IDLE, all outputs 0 except instr_ready=1, all registers 0; in-flight instruction discarded, no write.

## Timing
- Accept edge = cycle 0; res_valid high from cycle 3 (non-multiply).
- Write to regfile on the res_valid&&res_ready edge; next instruction's DECODE sees it (no hazard).
- Max throughput: one instruction per 4 cycles with res_ready held high.
- res_valid held, outputs unchanged, while res_ready low; no new instruction accepted.
- instr ignored whenever instr_ready=0.

## Configuration
- MIPS_MULT_EN defined: HI/LO registers (XLEN each, reset 0); funct MULT 0x18 (signed), MULTU 0x19, MFHI 0x10, MFLO 0x12. MULT/MULTU iterate shift-add one bit per cycle, EXEC occupies XLEN cycles (counter), signed via magnitude multiply then 2XLEN negate; HI/LO update on RESP handshake; res_wen=0, res_data=new LO. MFHI/MFLO write rd, 3-cycle latency. Reset mid-multiply leaves HI/LO 0.
- Not defined: no HI/LO, no counter; those functs are illegal.

## Test plan
- Reset then ADDI r1,r0,-5 (0x2001FFFB) -> res_valid at cycle 3, res_data 0xFFFFFFFB, res_wreg 1, res_wen 1; then SLTU r2,r0,r1 -> 1, SLT r3,r1,r0 -> 1.
- LUI r4,0x8000 then SRA r5,r4,4 -> 0xF8000000; SRL -> 0x08000000; SUB r6,r5,r5 -> 0, res_zero 1.
- res_ready low 5 cycles in RESP -> outputs stable, instr_ready 0, no regfile write until handshake; with res_ready high back-to-back instructions complete every 4 cycles.
- ADDI r0,r0,7 -> res_wen 0, later read of r0 = 0; opcode 0x3F -> res_illegal 1, res_data 0, no write.
- rst_n low during EXEC of ADDI r7,r0,9 -> IDLE immediately, r7 stays 0.
- MIPS_MULT_EN: r1=-3, r2=7, MULT r1,r2 -> res_valid after XLEN+2 cycles; MFLO -> 0xFFFFFFEB, MFHI -> 0xFFFFFFFF; MULTU 0xFFFFFFFF*2 -> HI 1, LO 0xFFFFFFFE.
